// File: rtl/load_cell_cond.sv
// load_cell_cond: load-cell smoothing filters, rider/difference qualification flags and settle timer
module load_cell_cond #(
    parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
    parameter logic [11:0] HYSTERESIS       = 12'h040,
    parameter int          FILT_SHIFT       = 2,
    parameter int          TMR_CYCLES       = 65_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ld_vld,
    input  logic        clr_tmr,
    output logic        sum_gt_min,
    output logic        sum_lt_min,
    output logic        diff_gt_1_4,
    output logic        diff_gt_15_16,
    output logic        tmr_full
);
    localparam int          AW      = 12 + FILT_SHIFT;
    localparam logic [12:0] LO      = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};
    localparam logic [12:0] HI      = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
    localparam logic [26:0] TMR_MAX = 27'(TMR_CYCLES);

    logic [AW-1:0] acc_l, acc_r;
    logic          seeded, v1, v2;
    logic [11:0]   fl, fr, diff_c, diff;
    logic [12:0]   sum_c, dsub, sum;
    logic [26:0]   cnt;

    // filtered values, their sum and magnitude of difference
    always_comb begin
        fl     = 12'(acc_l >> FILT_SHIFT);
        fr     = 12'(acc_r >> FILT_SHIFT);
        sum_c  = {1'b0, fl} + {1'b0, fr};
        dsub   = {1'b0, fl} - {1'b0, fr};
        diff_c = dsub[12] ? 12'(-dsub) : dsub[11:0];
    end

    // exponential smoothing; first sample after reset seeds the accumulator directly
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_l  <= '0;
            acc_r  <= '0;
            seeded <= 1'b0;
        end else if (ld_vld) begin
            acc_l  <= seeded ? acc_l - (acc_l >> FILT_SHIFT) + AW'(lft_ld) : AW'(lft_ld) << FILT_SHIFT;
            acc_r  <= seeded ? acc_r - (acc_r >> FILT_SHIFT) + AW'(rght_ld) : AW'(rght_ld) << FILT_SHIFT;
            seeded <= 1'b1;
        end
    end

    // stage 2: capture sum/diff the cycle after each filter update
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            sum  <= '0;
            diff <= '0;
        end else begin
            v1 <= ld_vld;
            if (v1) begin
                sum  <= sum_c;
                diff <= diff_c;
            end
        end
    end

    // stage 3: qualification flags, weight comparator with hysteresis
    always_ff @(posedge clk) begin
        if (rst) begin
            v2            <= 1'b0;
            sum_gt_min    <= 1'b0;
            sum_lt_min    <= 1'b0;
            diff_gt_1_4   <= 1'b0;
            diff_gt_15_16 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v2) begin
                sum_lt_min    <= sum < LO;
                sum_gt_min    <= (sum > HI) ? 1'b1 : (sum < LO) ? 1'b0 : sum_gt_min;
                diff_gt_1_4   <= {1'b0, diff} > (sum >> 2);
                diff_gt_15_16 <= {1'b0, diff} > sum - (sum >> 4);
            end
        end
    end

    // settle timer: clear wins, otherwise count up and saturate
    always_ff @(posedge clk) begin
        if (rst || clr_tmr)
            cnt <= '0;
        else if (cnt != TMR_MAX)
            cnt <= cnt + 27'd1;
    end

    assign tmr_full = (cnt == TMR_MAX);
endmodule

// File: tb/tb_load_cell_cond.sv
// tb_load_cell_cond: randomized + directed scoreboard bench for two filter strengths
module tb_load_cell_cond;
    localparam int TMR = 16;

    typedef struct {
        int       due;
        logic [3:0] e0;
        logic [3:0] e2;
    } exp_t;

    logic        clk, rst, ld_vld, clr_tmr;
    logic [11:0] lft_ld, rght_ld;
    logic        gt0, lt0, d14_0, d15_0, full0;
    logic        gt2, lt2, d14_2, d15_2, full2;

    exp_t       q[$];
    int         cyc, checks, errors;
    bit         started;
    int         m_acc_l[2], m_acc_r[2], m_cnt;
    bit         m_seed;
    bit         m_h[2];
    logic [3:0] cur0, cur2;

    load_cell_cond #(.FILT_SHIFT(0), .TMR_CYCLES(TMR)) u0 (
        .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld), .ld_vld(ld_vld), .clr_tmr(clr_tmr),
        .sum_gt_min(gt0), .sum_lt_min(lt0), .diff_gt_1_4(d14_0), .diff_gt_15_16(d15_0), .tmr_full(full0));

    load_cell_cond #(.FILT_SHIFT(2), .TMR_CYCLES(TMR)) u2 (
        .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld), .ld_vld(ld_vld), .clr_tmr(clr_tmr),
        .sum_gt_min(gt2), .sum_lt_min(lt2), .diff_gt_1_4(d14_2), .diff_gt_15_16(d15_2), .tmr_full(full2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock of stimulus; the reference model advances at the same edge
    task automatic step(input logic [11:0] l, input logic [11:0] r, input logic v, input logic c, input logic rs);
        exp_t e;
        int   sh, fl, fr, sum, diff;
        logic [3:0] f[2];
        lft_ld = l; rght_ld = r; ld_vld = v; clr_tmr = c; rst = rs;
        @(posedge clk);
        cyc++;
        if (rs) begin
            m_seed = 0; m_cnt = 0;
            for (int k = 0; k < 2; k++) begin
                m_acc_l[k] = 0; m_acc_r[k] = 0; m_h[k] = 0;
            end
            q.delete();
            e.due = cyc; e.e0 = 4'b0; e.e2 = 4'b0;
            q.push_back(e);
        end else begin
            m_cnt = c ? 0 : (m_cnt == TMR ? TMR : m_cnt + 1);
            if (v) begin
                for (int k = 0; k < 2; k++) begin
                    sh = k ? 2 : 0;
                    if (!m_seed) begin
                        m_acc_l[k] = int'(l) << sh;
                        m_acc_r[k] = int'(r) << sh;
                    end else begin
                        m_acc_l[k] = m_acc_l[k] - (m_acc_l[k] >> sh) + int'(l);
                        m_acc_r[k] = m_acc_r[k] - (m_acc_r[k] >> sh) + int'(r);
                    end
                    fl = m_acc_l[k] >> sh;
                    fr = m_acc_r[k] >> sh;
                    sum = fl + fr;
                    diff = fl > fr ? fl - fr : fr - fl;
                    if (sum > 'h240) m_h[k] = 1;
                    else if (sum < 'h1C0) m_h[k] = 0;
                    f[k] = {m_h[k], sum < 'h1C0, diff > sum / 4, diff > sum - sum / 16};
                end
                m_seed = 1;
                e.due = cyc + 2; e.e0 = f[0]; e.e2 = f[1];
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input logic [11:0] l, input logic [11:0] r);
        step(l, r, 1'b1, 1'b0, 1'b0);
        idle(3);
    endtask

    // monitor: retire due expectations, then compare every output of both instances
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            cur0 = q[0].e0;
            cur2 = q[0].e2;
            void'(q.pop_front());
        end
        if (started) begin
            checks++;
            if ({gt0, lt0, d14_0, d15_0, full0} !== {cur0, m_cnt == TMR}) begin
                errors++;
                $display("FAIL s0_outputs cyc=%0d got=%b exp=%b", cyc, {gt0, lt0, d14_0, d15_0, full0}, {cur0, m_cnt == TMR});
            end
            checks++;
            if ({gt2, lt2, d14_2, d15_2, full2} !== {cur2, m_cnt == TMR}) begin
                errors++;
                $display("FAIL s2_outputs cyc=%0d got=%b exp=%b", cyc, {gt2, lt2, d14_2, d15_2, full2}, {cur2, m_cnt == TMR});
            end
        end
    end

    initial begin
        cyc = 0; checks = 0; errors = 0; started = 0;
        cur0 = '0; cur2 = '0;
        step(12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        started = 1;
        step(12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // seed with a present rider
        strobe(12'h180, 12'h180);
        // hysteresis walk: sums 250, 1F0, 1B0, 1F0, 250
        strobe(12'h128, 12'h128);
        strobe(12'h0F8, 12'h0F8);
        strobe(12'h0D8, 12'h0D8);
        strobe(12'h0F8, 12'h0F8);
        strobe(12'h128, 12'h128);
        // difference ratios
        strobe(12'h300, 12'h100);
        strobe(12'h3F8, 12'h000);
        strobe(12'h155, 12'h155);
        strobe(12'h000, 12'h000);
        // filter decay from a fresh seed
        step(12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        strobe(12'h400, 12'h000);
        for (int i = 0; i < 3; i++) strobe(12'h000, 12'h000);
        // timer: saturate, clear, reassert, clear held
        step(12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
        idle(36);
        step(12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
        idle(20);
        for (int i = 0; i < 30; i++) step(12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
        // reset mid-count with flags set, then re-seed
        step(12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
        step(12'h300, 12'h000, 1'b1, 1'b0, 1'b0);
        idle(8);
        step(12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        strobe(12'h100, 12'h100);
        strobe(12'h080, 12'h080);
        // randomized traffic, including back-to-back strobes
        for (int i = 0; i < 2000; i++) begin
            logic [11:0] l, r;
            if ($urandom_range(0, 1)) begin
                l = 12'($urandom_range(0, 'h180));
                r = 12'($urandom_range(0, 'h180));
            end else begin
                l = 12'($urandom);
                r = 12'($urandom_range(0, 3)) == 0 ? 12'h0 : 12'($urandom);
            end
            step(l, r, 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0);
        end
        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_cell_cond.md
Name: load_cell_cond

Overview:
- Conditions the left/right rider load-cell samples and produces the qualification flags and 1.3 s settle timer consumed by the steering-enable state machine.
- Each channel gets an exponential smoothing filter. The block then forms sum and |difference|, runs hysteretic weight comparators and difference-ratio comparators, and owns the clearable saturating timer.
- Sits between the A2D/load-cell interface and steer_en_SM.

Parameters:
- MIN_RIDER_WEIGHT, 12'h200, nominal minimum rider weight (sum units).
- HYSTERESIS, 12'h040, half-width of the hysteresis band around MIN_RIDER_WEIGHT.
- FILT_SHIFT, 2, filter strength S; new = 1/2^S weight; legal 0..4.
- TMR_CYCLES, 65_000_000, clocks to tmr_full (1.3 s at 50 MHz); benches override to a small value.

Ports:
- clk, input, 1, 50 MHz system clock.
- rst, input, 1, synchronous active-high reset.
- lft_ld, input, 12, left load-cell sample, unsigned.
- rght_ld, input, 12, right load-cell sample, unsigned.
- ld_vld, input, 1, single-cycle strobe: lft_ld/rght_ld valid this cycle.
- clr_tmr, input, 1, synchronous timer clear from steer_en_SM.
- sum_gt_min, output, 1, hysteretic "rider present" flag.
- sum_lt_min, output, 1, filtered sum < MIN_RIDER_WEIGHT-HYSTERESIS.
- diff_gt_1_4, output, 1, |lft-rght| > sum/4.
- diff_gt_15_16, output, 1, |lft-rght| > sum*15/16.
- tmr_full, output, 1, timer has reached TMR_CYCLES.

Behaviour:
- Reset: rst sampled high at a rising clk edge zeroes all of the following:
  - filter accumulators;
  - the seeded flag;
  - pipeline registers;
  - timer;
  - every output.
  - rst takes priority over everything, including mid-pipeline and mid-count.
- Filter, per channel:
  - Accumulator acc is 12+FILT_SHIFT bits; filtered value f = acc>>FILT_SHIFT.
  - On the first ld_vld after reset (seeded=0): acc <= sample<<FILT_SHIFT, seeded <= 1.
  - On later ld_vld: acc <= acc - (acc>>FILT_SHIFT) + sample. This never overflows by construction.
  - Without ld_vld, acc holds.
- Stage 2, registered on the cycle after the filter update:
  - sum = fl+fr (13 bits).
  - diff = |fl-fr| (12 bits): subtract in 13-bit signed, then take magnitude.
- Stage 3, registered flags:
  - sum_lt_min <= (sum < MIN_RIDER_WEIGHT-HYSTERESIS).
  - sum_gt_min: set when sum > MIN_RIDER_WEIGHT+HYSTERESIS; cleared when sum < MIN_RIDER_WEIGHT-HYSTERESIS; otherwise holds.
  - diff_gt_1_4 <= (diff > sum>>2).
  - diff_gt_15_16 <= (diff > sum - (sum>>4)).
  - All compares unsigned, 13-bit, using truncating shifts.
- Latency: ld_vld at edge N updates acc at N, stage-2 regs at N+1, flags at N+2. Flags are stable between strobes.
- Back-to-back ld_vld: legal every cycle; the pipeline advances every cycle and stages 2/3 recompute continuously.
- Timer:
  - 27-bit counter. If clr_tmr: cnt <= 0. Else if cnt != TMR_CYCLES: cnt <= cnt+1. At TMR_CYCLES it saturates and holds.
  - tmr_full = (cnt == TMR_CYCLES), registered-equivalent, so it deasserts the cycle after the clr_tmr edge.
  - clr_tmr and saturation together: clear wins.
- Zero load: sum=0, diff=0, so both diff flags are 0 and sum_lt_min=1.

Test Plan:
- Reset/seed: assert rst 2 cycles, release. Check all outputs=0. Then one ld_vld with lft=rght=12'h180. Two edges later: sum=12'h300, sum_gt_min=1, sum_lt_min=0, both diff flags 0.
- Hysteresis (FILT_SHIFT=0): drive sums 12'h250, 12'h1F0, 12'h1B0, 12'h1F0, 12'h250. Required sum_gt_min sequence 1,1,0,0,1 (starting from set); sum_lt_min 0,0,1,0,0.
- Difference ratio (FILT_SHIFT=0):
  - lft=12'h300, rght=12'h100 (sum 400h, diff 200h) -> diff_gt_1_4=1, diff_gt_15_16=0.
  - lft=12'h3F8, rght=12'h000 -> both 1.
  - lft=rght -> both 0.
- Filter (FILT_SHIFT=2): seed lft=12'h400, then strobe 12'h000 repeatedly. f_left must be 12'h300, 12'h240, 12'h1B0.
- Timer (TMR_CYCLES=16):
  - Pulse clr_tmr, count 16 cycles -> tmr_full=1 and holds for 20 more cycles.
  - Pulse clr_tmr -> tmr_full=0 the next cycle, reasserts 16 cycles later.
  - clr_tmr held high -> tmr_full stays 0.
- Reset mid-operation: assert rst during count=10 with a flag set. Next cycle all outputs 0. The next ld_vld re-seeds the filter, with no blending from the old value.
